// File: rtl/alu_seq_ctrl_if.sv
// Bus bundle between the ALU sequencer and its environment: opcode input,
// step button, ALU completion flag, and the registered control outputs.
interface alu_seq_ctrl_if #(
  parameter int DATA_W  = 4,
  parameter int NUM_OPS = 5
) ();
  logic [DATA_W-1:0]  Datain;
  logic               readNext;
  logic               op_done;
  logic               ldA;
  logic               ldB;
  logic [NUM_OPS-1:0] op_en;
  logic               busy;
  logic               done;
  logic               err;

  // environment side: drives opcode/button/completion, observes controls
  modport master (
    output Datain, readNext, op_done,
    input  ldA, ldB, op_en, busy, done, err
  );

  // sequencer side
  modport slave (
    input  Datain, readNext, op_done,
    output ldA, ldB, op_en, busy, done, err
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Button-stepped ALU sequencer: load A, load B, fetch opcode, decode,
// then run one operation until op_done or timeout. All outputs registered.
module alu_seq_ctrl #(
  parameter int DATA_W     = 4,
  parameter int NUM_OPS    = 5,
  parameter int OP_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  alu_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, DECODE, EXEC} state_e;

  localparam logic [7:0]        TMO    = 8'(OP_TIMEOUT);
  localparam logic [DATA_W-1:0] MAX_OP = DATA_W'(NUM_OPS);

  state_e              state_q, state_d;
  logic                s1_q, s2_q, s3_q, s1_d, s2_d, s3_d;
  logic                step;
  logic [DATA_W-1:0]   opcode_q, opcode_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                lda_q, lda_d, ldb_q, ldb_d;
  logic [NUM_OPS-1:0]  op_en_q, op_en_d, dec_onehot;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                op_legal;

  // button synchronizer plus history flop; a step is the rising edge of s2
  always_comb begin
    s1_d = bus.readNext;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  assign step = s2_q & ~s3_q;

  // opcode k+1 selects enable bit k; 0 and anything above NUM_OPS are illegal
  always_comb begin
    op_legal = (opcode_q != '0) && (opcode_q <= MAX_OP);
    dec_onehot = '0;
    for (int k = 0; k < NUM_OPS; k++) dec_onehot[k] = (opcode_q == DATA_W'(k + 1));
  end

  // next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    cnt_d    = cnt_q;
    lda_d    = 1'b0;
    ldb_d    = 1'b0;
    op_en_d  = op_en_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      WAIT_A: if (step) begin
        lda_d   = 1'b1;
        err_d   = 1'b0;
        state_d = WAIT_B;
      end
      WAIT_B: if (step) begin
        ldb_d   = 1'b1;
        state_d = WAIT_OP;
      end
      WAIT_OP: if (step) begin
        opcode_d = bus.Datain;
        state_d  = DECODE;
      end
      DECODE: begin
        if (op_legal) begin
          op_en_d = dec_onehot;
          cnt_d   = 8'd1;
          state_d = EXEC;
        end else begin
          err_d   = 1'b1;
          state_d = WAIT_A;
        end
      end
      EXEC: begin
        // completion takes priority over a coincident timeout
        if (bus.op_done) begin
          op_en_d = '0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_A;
        end else if (cnt_q == TMO) begin
          op_en_d = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_A;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        op_en_d = '0;
        state_d = WAIT_A;
      end
    endcase
    busy_d = (state_d == DECODE) || (state_d == EXEC);
  end

  // state and output registers; synchronizer resets high so a held button
  // across reset release does not produce a step
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= WAIT_A;
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      s3_q     <= 1'b1;
      opcode_q <= '0;
      cnt_q    <= '0;
      lda_q    <= 1'b0;
      ldb_q    <= 1'b0;
      op_en_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
      lda_q    <= lda_d;
      ldb_q    <= ldb_d;
      op_en_q  <= op_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.ldA   = lda_q;
  assign bus.ldB   = ldb_q;
  assign bus.op_en = op_en_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: a default instance (4-bit, 5 ops) and a
// wide instance (6-bit, 12 ops) sharing button/op_done stimulus; sel picks
// which one is out of reset and observed.
module tb_alu_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       rn = 1'b0;
  logic       od = 1'b0;
  logic [7:0] dval = '0;
  logic       rst0, rst1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl_if #(.DATA_W(4), .NUM_OPS(5))  bus0 ();
  alu_seq_ctrl_if #(.DATA_W(6), .NUM_OPS(12)) bus1 ();

  assign rst0 = sel ? 1'b0 : rst_n;
  assign rst1 = sel ? rst_n : 1'b0;
  assign bus0.Datain   = dval[3:0];
  assign bus0.readNext = rn;
  assign bus0.op_done  = od;
  assign bus1.Datain   = dval[5:0];
  assign bus1.readNext = rn;
  assign bus1.op_done  = od;

  alu_seq_ctrl #(.DATA_W(4), .NUM_OPS(5), .OP_TIMEOUT(15)) dut0 (
    .clk(clk), .reset(rst0), .bus(bus0));
  alu_seq_ctrl #(.DATA_W(6), .NUM_OPS(12), .OP_TIMEOUT(15)) dut1 (
    .clk(clk), .reset(rst1), .bus(bus1));

  logic        m_lda, m_ldb, m_busy, m_done, m_err;
  logic [15:0] m_op_en;
  assign m_lda   = sel ? bus1.ldA  : bus0.ldA;
  assign m_ldb   = sel ? bus1.ldB  : bus0.ldB;
  assign m_busy  = sel ? bus1.busy : bus0.busy;
  assign m_done  = sel ? bus1.done : bus0.done;
  assign m_err   = sel ? bus1.err  : bus0.err;
  assign m_op_en = sel ? 16'(bus1.op_en) : 16'(bus0.op_en);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // button down; after the 3rd edge the step reaction is visible
  task automatic press3();
    rn = 1'b1;
    repeat (3) tick();
  endtask

  task automatic load_ab();
    press3();
    chk("ldA_step", 32'(m_lda), 1);
    chk("ldA_err_clr", 32'(m_err), 0);
    chk("ldA_no_ldB", 32'(m_ldb), 0);
    rn = 1'b0;
    tick();
    chk("ldA_1cyc", 32'(m_lda), 0);
    repeat (3) tick();
    press3();
    chk("ldB_step", 32'(m_ldb), 1);
    chk("ldB_no_ldA", 32'(m_lda), 0);
    rn = 1'b0;
    tick();
    chk("ldB_1cyc", 32'(m_ldb), 0);
    repeat (3) tick();
  endtask

  // third step with opcode dv; returns one cycle after DECODE
  task automatic issue_op(input logic [7:0] dv);
    dval = dv;
    press3();
    chk("decode_busy", 32'(m_busy), 1);
    chk("decode_op_en", 32'(m_op_en), 0);
    rn = 1'b0;
    dval = 8'hFF;
    tick();
  endtask

  task automatic run_ok(input logic [7:0] dv, input logic [15:0] exp, input int ncyc);
    load_ab();
    issue_op(dv);
    for (int i = 1; i <= ncyc; i++) begin
      chk("exec_op_en", 32'(m_op_en), 32'(exp));
      chk("exec_busy", 32'(m_busy), 1);
      if (i < ncyc) tick();
    end
    od = 1'b1;
    tick();
    od = 1'b0;
    chk("done_pulse", 32'(m_done), 1);
    chk("done_op_en_off", 32'(m_op_en), 0);
    chk("done_err", 32'(m_err), 0);
    chk("done_idle", 32'(m_busy), 0);
    tick();
    chk("done_1cyc", 32'(m_done), 0);
    tick();
  endtask

  task automatic run_bad(input logic [7:0] dv);
    load_ab();
    issue_op(dv);
    chk("bad_err", 32'(m_err), 1);
    chk("bad_op_en", 32'(m_op_en), 0);
    chk("bad_idle", 32'(m_busy), 0);
    chk("bad_no_done", 32'(m_done), 0);
    repeat (2) tick();
    chk("bad_err_sticky", 32'(m_err), 1);
  endtask

  task automatic run_timeout(input logic [7:0] dv, input logic [15:0] exp);
    int n;
    load_ab();
    issue_op(dv);
    n = 0;
    while (m_op_en == exp && n < 40) begin
      n++;
      tick();
    end
    chk("tmo_cycles", 32'(n), 15);
    chk("tmo_err", 32'(m_err), 1);
    chk("tmo_no_done", 32'(m_done), 0);
    chk("tmo_idle", 32'(m_busy), 0);
    tick();
  endtask

  task automatic rst_in_exec(input logic [7:0] dv, input logic [15:0] exp);
    int n;
    load_ab();
    dval = dv;
    press3();
    tick();
    chk("rx_op_en", 32'(m_op_en), 32'(exp));
    tick();
    rst_n = 1'b0;
    tick();
    chk("rx_outs_zero", 32'({m_lda, m_ldb, m_busy, m_done, m_err, m_op_en}), 0);
    rst_n = 1'b1;
    n = 0;
    repeat (8) begin
      tick();
      n += 32'(m_lda);
    end
    chk("rx_held_no_step", 32'(n), 0);
    rn = 1'b0;
    repeat (4) tick();
    press3();
    chk("rx_repress_ldA", 32'(m_lda), 1);
    rn = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d;
    repeat (2) tick();
    chk("rst_outs", 32'({m_lda, m_ldb, m_busy, m_done, m_err, m_op_en}), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_no_step", 32'(m_lda), 0);

    run_ok(8'd2, 16'h0002, 2);
    run_bad(8'd0);
    run_bad(8'd6);
    run_bad(8'd15);
    run_timeout(8'd5, 16'h0010);
    run_ok(8'd5, 16'h0010, 15);
    run_ok(8'd1, 16'h0001, 1);

    // long hold gives a single step
    rn = 1'b1;
    n = 0;
    repeat (100) begin
      tick();
      n += 32'(m_lda);
    end
    chk("held_one_ldA", 32'(n), 1);
    rn = 1'b0;
    repeat (4) tick();
    // sub-cycle glitch straddling one edge gives a single step
    #5 rn = 1'b1;
    #6 rn = 1'b0;
    n = 0;
    repeat (8) begin
      tick();
      n += 32'(m_ldb);
    end
    chk("glitch_one_ldB", 32'(n), 1);
    // press during EXEC is discarded
    dval = 8'd1;
    press3();
    chk("pe_decode", 32'(m_busy), 1);
    rn = 1'b0;
    repeat (4) tick();
    rn = 1'b1;
    repeat (4) tick();
    rn = 1'b0;
    repeat (4) tick();
    chk("pe_still_exec", 32'(m_op_en), 1);
    od = 1'b1;
    tick();
    chk("pe_done", 32'(m_done), 1);
    // op_done outside EXEC is ignored, and no queued step appears
    n = 0;
    d = 0;
    repeat (10) begin
      tick();
      n += 32'(m_lda);
      d += 32'(m_done);
    end
    od = 1'b0;
    chk("pe_no_queued_step", 32'(n), 0);
    chk("od_ignored_idle", 32'(d), 0);

    rst_in_exec(8'd3, 16'h0004);

    // wide instance
    rst_n = 1'b0;
    sel = 1'b1;
    repeat (2) tick();
    chk("w_rst_outs", 32'({m_lda, m_ldb, m_busy, m_done, m_err, m_op_en}), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    run_ok(8'd12, 16'h0800, 3);
    run_bad(8'd13);
    run_ok(8'd6, 16'h0020, 1);
    rst_in_exec(8'd12, 16'h0800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set the Datain width and opcode width.
REQ-002 Parameter NUM_OPS, default 5, SHALL set the operation-strobe count; legal range 1..2**DATA_W-1.
REQ-003 Parameter OP_TIMEOUT, default 15, SHALL set the maximum EXEC cycles awaiting op_done; legal range 1..255.
REQ-004 clk  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-005 reset  input  1  SHALL be the synchronous, active-low reset.
REQ-006 Datain  input  DATA_W  SHALL carry the opcode, sampled on the third step.
REQ-007 readNext  input  1  SHALL be the asynchronous step button, level, active-high.
REQ-008 op_done  input  1  SHALL be the ALU completion flag, sampled only in EXEC.
REQ-009 ldA  output  1  SHALL be the one-cycle load-operand-A strobe.
REQ-010 ldB  output  1  SHALL be the one-cycle load-operand-B strobe.
REQ-011 op_en  output  NUM_OPS  SHALL be the one-hot operation enable; bit k means opcode k+1.
REQ-012 busy  output  1  SHALL be high in DECODE and EXEC.
REQ-013 done  output  1  SHALL be a one-cycle pulse on successful completion.
REQ-014 err  output  1  SHALL be the sticky error flag for illegal opcode or timeout.

Function
REQ-015 readNext SHALL pass through a 2-flop synchronizer s1->s2, plus a history flop s3; step = s2 & ~s3.
REQ-016 All outputs SHALL be registered; ldA SHALL rise at the 3rd rising edge, counting the first edge that samples readNext=1.
REQ-017 States SHALL be WAIT_A, WAIT_B, WAIT_OP, DECODE, EXEC.
REQ-018 WAIT_A, on step: ldA=1 for one cycle, err cleared, go WAIT_B; else hold.
REQ-019 WAIT_B, on step: ldB=1 for one cycle, go WAIT_OP; else hold.
REQ-020 WAIT_OP, on step: capture Datain into opcode register, go DECODE; else hold.
REQ-021 DECODE SHALL last one cycle; opcode 1..NUM_OPS: go EXEC, op_en[opcode-1]=1 from the first EXEC cycle; opcode 0 or >NUM_OPS: err=1, go WAIT_A, op_en stays 0.
REQ-022 EXEC SHALL hold op_en constant and count cycles from 1; op_done=1: next cycle op_en=0, done=1, go WAIT_A.
REQ-023 EXEC, count==OP_TIMEOUT with op_done=0: next cycle op_en=0, err=1, done=0, go WAIT_A.
REQ-024 op_done and timeout in the same cycle: op_done SHALL win, with done=1 and err unchanged.
REQ-025 Steps in DECODE or EXEC SHALL be discarded, not queued; a new press is needed after return to WAIT_A.
REQ-026 A held button SHALL give exactly one step; release then press gives the next.
REQ-027 Datain SHALL be ignored outside the WAIT_OP step cycle; op_done SHALL be ignored outside EXEC.
REQ-028 op_en SHALL never have more than one bit set, and ldA, ldB, op_en SHALL never be asserted together.

Reset
REQ-029 reset=0 at a rising edge SHALL force WAIT_A, with ldA, ldB, op_en, busy, done, err, opcode and the cycle counter all 0.
REQ-030 Reset SHALL set s1, s2, s3 to 1, so a button held through reset release gives no step.
REQ-031 Reset in any state, including EXEC with op_en active, SHALL deassert all strobes at that edge with no done or err.

Verification
REQ-032 Press, release, press, release, then press with Datain=2 and op_done=1 two EXEC cycles later -> ldA pulse, ldB pulse, op_en=5'b00010 for 2 cycles, done pulse, return to WAIT_A.
REQ-033 Third press with Datain=0, then again with Datain=6 (NUM_OPS=5) -> op_en stays 0, err=1 after DECODE, err cleared at the next ldA pulse.
REQ-034 Opcode 5 with op_done held 0 -> op_en=5'b10000 for exactly 15 cycles, then err=1 and WAIT_A; variant with op_done=1 on cycle 15 -> done=1, err=0.
REQ-035 readNext held high 100 cycles, then a glitch shorter than 1 cycle -> exactly one ldA pulse; a press during EXEC -> no effect after return.
REQ-036 reset=0 during EXEC with readNext held high through release -> all outputs 0 at that edge, no step until release and re-press; repeat with DATA_W=6, NUM_OPS=12.
